// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding word read, a small word queue
// feeding the Prefetch Buffer, and redirect/flush handling. Option: FETCH_PERF_EN.
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              pb_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       exInst,
  output logic              write,
  output logic              skip_lo,
  output logic [ADDR_W-1:0] fetch_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_stall
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] target_reg;
  logic              req_reg;
  logic              first_reg;
  logic              skip_reg;
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [31:0]       mem [DEPTH];

  logic              ack_ok;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_after_pop;
  logic [CNT_W-1:0]  count_next;
  logic              idle_slot;
  logic              req_slot;
  logic [ADDR_W-1:0] target;
  logic              unused_pc_bit;

  assign unused_pc_bit = redirect_pc[0];
  assign target        = {redirect_pc[ADDR_W-1:2], 2'b00};

  // An ack in the first cycle of a request cannot be a real response.
  assign ack_ok = imem_ack && req_reg && !first_reg;

  assign write = (count_reg != '0);
  assign pop   = write && pb_ready && !redirect;
  assign push  = ack_ok && (state == REQ) && !redirect;

  assign count_after_pop = count_reg - CNT_W'(pop);
  assign count_next      = count_reg + CNT_W'(push) - CNT_W'(pop);
  assign idle_slot       = (count_after_pop < DEPTH_C);
  assign req_slot        = (count_next < DEPTH_C);

  assign imem_req  = req_reg;
  assign imem_addr = pc_reg;
  assign fetch_pc  = pc_reg;
  assign exInst    = write ? mem[head_reg] : 32'h0;
  assign skip_lo   = write && skip_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc_reg     <= '0;
      target_reg <= '0;
      req_reg    <= 1'b0;
      first_reg  <= 1'b0;
    end else begin
      first_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (redirect || idle_slot) begin
            state     <= REQ;
            req_reg   <= 1'b1;
            first_reg <= 1'b1;
            if (redirect) pc_reg <= target;
          end
        end
        REQ: begin
          if (ack_ok) begin
            if (redirect) pc_reg <= target;
            else          pc_reg <= pc_reg + ADDR_W'(4);
            // A redirect empties the queue, so a slot is always free then.
            if (redirect || req_slot) begin
              first_reg <= 1'b1;
            end else begin
              state   <= IDLE;
              req_reg <= 1'b0;
            end
          end else if (redirect) begin
            target_reg <= target;
            state      <= FLUSH;
          end
        end
        FLUSH: begin
          if (ack_ok) begin
            state     <= REQ;
            first_reg <= 1'b1;
            pc_reg    <= redirect ? target : target_reg;
          end else if (redirect) begin
            target_reg <= target;
          end
        end
        default: begin
          state   <= IDLE;
          req_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      skip_reg  <= 1'b0;
    end else if (redirect) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      skip_reg  <= redirect_pc[1];
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
        skip_reg <= 1'b0;
      end
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_reg] <= imem_rdata;
  end

`ifdef FETCH_PERF_EN
  logic [15:0] stall_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_reg <= 16'h0;
    end else if (redirect) begin
      stall_reg <= 16'h0;
    end else if (write && !pb_ready && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'h1;
    end
  end

  assign perf_stall = stall_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reset vector table, directed redirect/stall/wrap/reset
// sequences, and random traffic scored against an address-stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        pb_ready = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] exInst;
  logic        write;
  logic        skip_lo;
  logic [15:0] fetch_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall;
`endif

  fetch_unit #(.ADDR_W(16), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .pb_ready(pb_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .exInst(exInst),
    .write(write), .skip_lo(skip_lo), .fetch_pc(fetch_pc)
`ifdef FETCH_PERF_EN
    , .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory image and memory-side model
  logic [31:0] tb_mem [0:16383];
  bit          trk = 0;
  logic [15:0] trk_addr = 16'h0;
  int          trk_cnt = 0;
  int          mem_lat = 1;
  bit          rand_lat = 0;
  int          new_req_cnt = 0;
  logic [15:0] last_req_addr = 16'h0;

  // Delivery model: the stream must be consecutive words from the last target
  logic [15:0] exp_addr = 16'h0;
  logic        exp_skip = 1'b0;
  logic [15:0] exp_perf = 16'h0;
  int          n_xfer = 0;

  bit          redir_on_ack = 0;
  logic [15:0] ro_pc = 16'h0;
  bit          ro_hit = 0;
  bit          found = 0;
  int          snap = 0;

  typedef struct packed {
    logic        pb;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [15:0] addr;
    logic        wr;
    logic [31:0] inst;
    logic        skip;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    trk      = 0;
    exp_addr = 16'h0;
    exp_skip = 1'b0;
    exp_perf = 16'h0;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b0;
    pb_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // One clock: answer memory, score any transfer, then advance past the edge.
  task automatic step();
`ifdef FETCH_PERF_EN
    chk("perf_stall", perf_stall, exp_perf);
`endif
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (trk) chk("req_held", imem_req, 1'b1);
    if (imem_req) begin
      if (trk) begin
        chk("req_hold_addr", imem_addr, trk_addr);
        trk_cnt--;
        if (trk_cnt <= 0) begin
          imem_ack   = 1'b1;
          imem_rdata = tb_mem[imem_addr[15:2]];
          trk        = 0;
        end
      end else begin
        trk           = 1;
        trk_addr      = imem_addr;
        trk_cnt       = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        new_req_cnt++;
        last_req_addr = imem_addr;
      end
    end else begin
      trk = 0;
    end
    if (redir_on_ack && imem_ack && write) begin
      redirect     = 1'b1;
      redirect_pc  = ro_pc;
      pb_ready     = 1'b1;
      redir_on_ack = 0;
      ro_hit       = 1;
    end
    if (redirect) begin
      exp_addr = {redirect_pc[15:2], 2'b00};
      exp_skip = redirect_pc[1];
    end else if (write && pb_ready) begin
      chk($sformatf("deliver@%04h", exp_addr), {skip_lo, exInst}, {exp_skip, tb_mem[exp_addr[15:2]]});
      exp_addr = exp_addr + 16'd4;
      exp_skip = 1'b0;
      n_xfer++;
    end
    if (redirect) exp_perf = 16'h0;
    else if (write && !pb_ready && exp_perf != 16'hFFFF) exp_perf = exp_perf + 16'h1;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  task automatic wait_new_req(input string name, input logic [15:0] want);
    int s;
    bit got;
    s = new_req_cnt;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (new_req_cnt != s) got = 1;
    end
    chk({name, "_seen"}, got, 1'b1);
    if (got) chk(name, last_req_addr, want);
  endtask

  task automatic wait_xfers(input string name, input int n);
    int s;
    s = n_xfer;
    for (int i = 0; i < 60 && (n_xfer - s) < n; i++) step();
    chk(name, n_xfer - s, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) tb_mem[i] = $urandom;
    tb_mem[0] = 32'h11112222;
    tb_mem[1] = 32'h33334444;

    //           pb    ack   rdata          req   addr     wr    inst           skip
    vecs[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 16'h0000, 1'b0, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0,        1'b1, 16'h0000, 1'b0, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h11112222, 1'b1, 16'h0000, 1'b0, 32'h0,        1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0,        1'b1, 16'h0004, 1'b1, 32'h11112222, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h33334444, 1'b1, 16'h0004, 1'b0, 32'h0,        1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0,        1'b1, 16'h0008, 1'b1, 32'h33334444, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0,        1'b1, 16'h0008, 1'b0, 32'h0,        1'b0};

    // Reset values
    #12;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 16'h0);
    chk("rst_fetch_pc", fetch_pc, 16'h0);
    chk("rst_write", write, 1'b0);
    chk("rst_exinst", exInst, 32'h0);
    chk("rst_skip", skip_lo, 1'b0);
`ifdef FETCH_PERF_EN
    chk("rst_perf", perf_stall, 16'h0);
`endif

    // Cycle-by-cycle vectors from reset release
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("vec%0d", i),
          {imem_req, imem_addr, fetch_pc, write, exInst, skip_lo},
          {vecs[i].req, vecs[i].addr, vecs[i].addr, vecs[i].wr, vecs[i].inst, vecs[i].skip});
      pb_ready   = vecs[i].pb;
      imem_ack   = vecs[i].ack;
      imem_rdata = vecs[i].rdata;
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;

    // Back-pressure: queue fills, requests stop, then drain in order and resume
    do_reset();
    mem_lat = 1;
    rand_lat = 0;
    for (int i = 0; i < 12; i++) begin
      if (i >= 6) chk($sformatf("full_noreq%0d", i), imem_req, 1'b0);
      step();
    end
    chk("full_write", write, 1'b1);
    snap = n_xfer;
    pb_ready = 1'b1;
    step();
    chk("resume_req", imem_req, 1'b1);
    chk("resume_addr", imem_addr, 16'h0008);
    step();
    chk("drain_two", n_xfer - snap, 2);

    // Redirect to 0x0042 during the 0x0010 request, ack three cycles later
    do_reset();
    pb_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (imem_req && imem_addr == 16'h0010 && !trk) begin
        found = 1;
        mem_lat = 3;
        redirect = 1'b1;
        redirect_pc = 16'h0042;
      end
      step();
    end
    mem_lat = 1;
    chk("reach_0010", found, 1'b1);
    wait_new_req("flush_target", 16'h0040);
    wait_xfers("after_flush_xfers", 2);

    // Redirect coinciding with ack and with a queue pop
    do_reset();
    ro_pc = 16'h0100;
    ro_hit = 0;
    redir_on_ack = 1;
    for (int i = 0; i < 30 && !ro_hit; i++) step();
    redir_on_ack = 0;
    chk("coincide_hit", ro_hit, 1'b1);
    chk("coincide_empty", write, 1'b0);
    chk("coincide_req", imem_req, 1'b1);
    chk("coincide_addr", imem_addr, 16'h0100);
    pb_ready = 1'b1;
    wait_xfers("coincide_xfer", 1);

    // Address wrap-around
    redirect = 1'b1;
    redirect_pc = 16'hFFFC;
    step();
    wait_new_req("wrap_pre", 16'hFFFC);
    wait_new_req("wrap_post", 16'h0000);
    wait_xfers("wrap_xfers", 2);

    // Random traffic
    rand_lat = 1;
    snap = n_xfer;
    for (int i = 0; i < 3000; i++) begin
      pb_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) begin
        redirect = 1'b1;
        redirect_pc = 16'($urandom);
      end
      step();
    end
    chk("random_progress", (n_xfer - snap) > 100, 1'b1);

    // Reset in the middle of a request, late acks while in reset
    rand_lat = 0;
    mem_lat = 3;
    pb_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req) found = 1;
      else step();
    end
    chk("midreq_reached", found, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("midreset_req", imem_req, 1'b0);
    chk("midreset_write", write, 1'b0);
    model_reset();
    mem_lat = 1;
    repeat (2) begin
      @(negedge clk);
      imem_ack = 1'b1;
      imem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      imem_ack = 1'b0;
    end
    imem_ack = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("postreset_write", write, 1'b0);
`ifdef FETCH_PERF_EN
    chk("postreset_perf", perf_stall, 16'h0);
`endif
    wait_new_req("postreset_addr", 16'h0000);
    wait_xfers("postreset_xfers", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the NanoQuarter pipeline. It is the writer side of the Prefetch Buffer write interface.
- It issues word reads to instruction memory over a req/ack handshake and holds returned 32-bit words in a small queue.
- It pushes each word to the Prefetch Buffer as exInst (low halfword = earlier instruction) qualified by write.
- It handles jump/branch redirects by discarding in-flight and queued words.

Parameters:
- ADDR_W, 16, byte-address width of the fetch PC and imem_addr
- DEPTH, 2, word-queue entries (power of 2, at least 2)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc
- redirect_pc  in  ADDR_W  new target byte address, halfword-aligned (bit0 ignored)
- pb_ready  in  1  Prefetch Buffer can accept a 32-bit write this cycle
- imem_req  out  1  read request to instruction memory
- imem_addr  out  ADDR_W  word-aligned address (bits[1:0]=0)
- imem_ack  in  1  read data valid; completes the outstanding request
- imem_rdata  in  32  returned instruction word
- exInst  out  32  word to Prefetch Buffer
- write  out  1  exInst valid; a transfer occurs when write && pb_ready
- skip_lo  out  1  with write: low halfword must be discarded (odd-halfword redirect target)
- fetch_pc  out  ADDR_W  address of the word currently in imem_addr

Behaviour:
- Reset (rst=0, async) values:
  - imem_req=0, imem_addr=0, fetch_pc=0, write=0, exInst=0, skip_lo=0
  - queue empty, state=IDLE, skip pending=0
  - First rising edge after release moves to REQ at address 0.
- Requests:
  - At most one request outstanding.
  - imem_req and imem_addr are held stable from assertion until imem_ack.
  - Minimum memory latency is 1 cycle: ack may arrive the cycle after req rises. Ack in the same cycle req first rises is ignored.
- FSM:
  - IDLE: go to REQ when queue has a free slot, counting the slot freed by a same-cycle pop.
  - REQ (req=1): on ack, push imem_rdata and fetch_pc+=4. Then stay in REQ if a slot remains after the push, else go to IDLE.
  - FLUSH (req=1, data discarded): on ack, drop the data, load fetch_pc from the latched target, go to REQ.
- Queue:
  - Circular FIFO, DEPTH entries, pointers wrap at DEPTH.
  - write = queue nonempty; exInst = head entry, combinationally from registers.
  - Pop on write && pb_ready. Push and pop in the same cycle keep the count unchanged. Full queue never requests.
- Redirect:
  - Queue is cleared in the same cycle; that cycle's pop is suppressed, so no stale word is delivered.
  - Target word address = {redirect_pc[ADDR_W-1:2],2'b00}.
  - No request outstanding: fetch_pc loads the target and state goes to REQ next cycle.
  - Request outstanding: latch the target, go to FLUSH. Request stays asserted at the old address until ack.
  - A redirect that coincides with ack: that data is dropped.
  - A second redirect while in FLUSH overwrites the latched target.
  - If redirect_pc[1]=1, skip_lo is set for the first word delivered after the redirect, then cleared.
- Wrap-around: fetch_pc increments modulo 2^ADDR_W (0xFFFC -> 0x0000), no error.
- Reset mid-request: all state is cleared immediately. A late ack arriving after reset, while imem_req=0, is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output perf_stall [15:0].
  - Counts cycles with write=1 && pb_ready=0, saturating at 0xFFFF.
  - Cleared by reset and by redirect.
- Undefined: no port, no counter logic.

Test Plan:
- Reset release, memory returns 0x11112222 then 0x33334444, 1-cycle latency, pb_ready=1:
  - imem_addr sequence is 0x0000, 0x0004.
  - exInst=0x11112222 with write=1, then 0x33334444.
  - skip_lo=0.
- pb_ready=0 with DEPTH=2:
  - After two acks, imem_req drops and stays 0.
  - On pb_ready=1, words are delivered in order, then fetching resumes at 0x0008.
- Redirect to 0x0042 while a request to 0x0010 is outstanding, ack 3 cycles later:
  - The 0x0010 data is never written.
  - The next request is to 0x0040.
  - The first delivered word carries skip_lo=1, the following word skip_lo=0.
- Redirect in the same cycle as ack and as write && pb_ready:
  - Neither word is delivered.
  - Queue is empty the next cycle and the next request targets the redirect word.
- fetch_pc=0xFFFC, ack: next imem_addr=0x0000.
- rst=0 asserted mid-request, then ack pulses while in reset:
  - imem_req=0 immediately, write=0.
  - After release, the first request is to 0x0000 with no stale data delivered.
  - With FETCH_PERF_EN, perf_stall reads 0.
